// File: rtl/gmii_tx_framer_if.sv
// Byte-stream input from the arbiter and GMII transmit outputs of the framer.
// The upstream/bench side takes the master modport; the framer takes the slave modport.
interface gmii_tx_framer_if;
    logic [7:0] Input_data;
    logic       Input_valid;
    logic       Input_last;
    logic [7:0] Gmii_txd;
    logic       Gmii_tx_en;
    logic       Gmii_tx_er;
    logic       Overrun_pulse;

    modport master (
        output Input_data, Input_valid, Input_last,
        input  Gmii_txd, Gmii_tx_en, Gmii_tx_er, Overrun_pulse
    );

    modport slave (
        input  Input_data, Input_valid, Input_last,
        output Gmii_txd, Gmii_tx_en, Gmii_tx_er, Overrun_pulse
    );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, CRC-32 FCS append and inter-frame gap.
// Payload waits in an 8-stage delay line while the preamble goes out; input has no backpressure.
module gmii_tx_framer #(
    parameter int IFG_LEN = 12
) (
    input  logic            Clk,
    input  logic            Rst,
    gmii_tx_framer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_FCS, S_GAP} state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       last;
    } slot_t;

    localparam int DEPTH = 8;
    // The first GAP cycle already overlaps the first idle output cycle, hence the -2.
    localparam logic [15:0] GAP_END = 16'(IFG_LEN - 2);

    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        capture_q, capture_d;
    logic        drop_q, drop_d;
    slot_t       line_q [DEPTH];
    slot_t       line_d [DEPTH];
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        ovr_q, ovr_d;

    slot_t       in_slot;
    slot_t       head;
    logic        accept;
    logic [31:0] fcs;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        capture_d = capture_q;
        drop_d    = drop_q;
        txd_d     = 8'h00;
        tx_en_d   = 1'b0;
        tx_er_d   = 1'b0;
        ovr_d     = 1'b0;
        accept    = 1'b0;
        in_slot   = '{data: bus.Input_data, valid: 1'b0, last: 1'b0};
        head      = line_q[DEPTH-1];
        fcs       = ~crc_q;

        // A frame start outside IDLE is dropped whole, up to and including its last byte.
        if (bus.Input_valid) begin
            if (drop_q) begin
                if (bus.Input_last) drop_d = 1'b0;
            end else if (capture_q || state_q == S_IDLE) begin
                in_slot.valid = 1'b1;
                in_slot.last  = bus.Input_last;
                accept        = !capture_q;
                capture_d     = !bus.Input_last;
            end else begin
                ovr_d  = 1'b1;
                drop_d = !bus.Input_last;
            end
        end

        line_d[0] = in_slot;
        for (int i = 1; i < DEPTH; i++) line_d[i] = line_q[i-1];

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PREAMBLE;
                    cnt_d   = 16'd0;
                    txd_d   = 8'h55;
                    tx_en_d = 1'b1;
                end
            end
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                crc_d   = 32'hFFFF_FFFF;
                if (cnt_q == 16'd6) begin
                    txd_d   = 8'hD5;
                    state_d = S_DATA;
                end else begin
                    txd_d = 8'h55;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                if (head.valid) begin
                    txd_d = head.data;
                    crc_d = crc_byte(crc_q, head.data);
                    if (head.last) begin
                        state_d = S_FCS;
                        cnt_d   = 16'd0;
                    end
                end else begin
                    tx_er_d = 1'b1;
                end
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q == 16'd3) begin
                    state_d = S_GAP;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_END) state_d = S_IDLE;
                else                  cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            crc_q     <= 32'hFFFF_FFFF;
            capture_q <= 1'b0;
            drop_q    <= 1'b0;
            txd_q     <= 8'h00;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            ovr_q     <= 1'b0;
            // NOTE: the delay line is reset because stale valid bits would leak into the next frame.
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            capture_q <= capture_d;
            drop_q    <= drop_d;
            txd_q     <= txd_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            ovr_q     <= ovr_d;
            line_q    <= line_d;
        end
    end

    assign bus.Gmii_txd      = txd_q;
    assign bus.Gmii_tx_en    = tx_en_q;
    assign bus.Gmii_tx_er    = tx_er_q;
    assign bus.Overrun_pulse = ovr_q;
endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: stimulus queues expected GMII frames and overrun
// pulses, a negedge monitor collects frames and pops/compares them.
module tb_gmii_tx_framer;
    localparam int IFG_LEN = 12;
    typedef logic [7:0] bytes_t [$];

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    gmii_tx_framer_if bus();

    gmii_tx_framer #(.IFG_LEN(IFG_LEN)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_bytes_q [$];
    int         exp_len_q   [$];
    int         exp_start_q [$];
    int         exp_ovr_q   [$];
    int         skip_frames = 0;
    int         last_gap    = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference CRC-32: non-reflected serial LFSR fed LSB-first, output bit-reversed and inverted.
    function automatic logic [31:0] crc_ref(input bytes_t pl);
        logic [31:0] r;
        logic [31:0] out;
        logic        fb;
        r = 32'hFFFF_FFFF;
        foreach (pl[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[31] ^ pl[i][b];
                r  = r << 1;
                if (fb) r = r ^ 32'h04C1_1DB7;
            end
        end
        for (int i = 0; i < 32; i++) out[i] = r[31-i];
        return ~out;
    endfunction

    // ---------------- monitor ----------------
    logic [8:0] rx_q [$];
    bit         in_frame = 1'b0;
    int         rx_start = 0;
    int         last_end = 0;

    task automatic compare_frame();
        int         len;
        int         st;
        logic [8:0] e;
        bit         ok;
        if (skip_frames > 0) begin
            skip_frames--;
        end else if (exp_len_q.size() == 0) begin
            check("unexpected_frame", rx_q.size(), 0);
        end else begin
            len = exp_len_q.pop_front();
            st  = exp_start_q.pop_front();
            ok  = 1'b1;
            check("frame_start", rx_start, st);
            check("frame_len", rx_q.size(), len);
            for (int i = 0; i < len; i++) begin
                e = exp_bytes_q.pop_front();
                if (ok && i < rx_q.size()) begin
                    check($sformatf("frame_byte%0d", i), {23'h0, rx_q[i]}, {23'h0, e});
                    if (rx_q[i] !== e) ok = 1'b0;
                end
            end
        end
    endtask

    always @(negedge Clk) begin
        if (bus.Gmii_tx_er && !bus.Gmii_tx_en) check("er_without_en", 1, 0);
        if (bus.Overrun_pulse) begin
            if (exp_ovr_q.size() == 0) check("unexpected_overrun", 1, 0);
            else                       check("overrun_cycle", cyc, exp_ovr_q.pop_front());
        end
        if (bus.Gmii_tx_en) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                rx_start = cyc;
                last_gap = cyc - last_end;
                rx_q.delete();
            end
            rx_q.push_back({bus.Gmii_tx_er, bus.Gmii_txd});
            last_end = cyc;
        end else if (in_frame) begin
            in_frame = 1'b0;
            compare_frame();
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            bus.Input_valid = 1'b0;
            bus.Input_last  = 1'b0;
            bus.Input_data  = 8'($urandom);
        end
    endtask

    // Sends a frame; gap_pos >= 0 inserts one invalid cycle after that payload index.
    task automatic send(input bytes_t pl, input int gap_pos, input bit expect_tx,
                        input bit use_const, input logic [31:0] fcs_const);
        logic [31:0] fcs;
        int          n;
        int          t;
        n   = pl.size();
        fcs = use_const ? fcs_const : crc_ref(pl);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            bus.Input_valid = 1'b1;
            bus.Input_data  = pl[i];
            bus.Input_last  = (i == n - 1);
            if (i == 0) begin
                t = cyc;
                if (expect_tx) begin
                    exp_start_q.push_back(t + 1);
                    exp_len_q.push_back(12 + n + ((gap_pos >= 0 && gap_pos < n - 1) ? 1 : 0));
                    for (int k = 0; k < 7; k++) exp_bytes_q.push_back({1'b0, 8'h55});
                    exp_bytes_q.push_back({1'b0, 8'hD5});
                    for (int k = 0; k < n; k++) begin
                        exp_bytes_q.push_back({1'b0, pl[k]});
                        if (k == gap_pos && k != n - 1) exp_bytes_q.push_back({1'b1, 8'h00});
                    end
                    for (int k = 0; k < 4; k++) exp_bytes_q.push_back({1'b0, fcs[8*k +: 8]});
                end else begin
                    exp_ovr_q.push_back(t + 1);
                end
            end
            if (i == gap_pos && i != n - 1) begin
                @(negedge Clk);
                bus.Input_valid = 1'b0;
                bus.Input_last  = 1'b0;
            end
        end
    endtask

    function automatic bytes_t rand_bytes(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txd"},   {24'h0, bus.Gmii_txd}, 32'h0);
        check({tag, "_en"},    {31'h0, bus.Gmii_tx_en}, 32'h0);
        check({tag, "_er"},    {31'h0, bus.Gmii_tx_er}, 32'h0);
        check({tag, "_ovr"},   {31'h0, bus.Overrun_pulse}, 32'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bytes_t p;
        bus.Input_valid = 1'b0;
        bus.Input_last  = 1'b0;
        bus.Input_data  = 8'h00;
        repeat (4) @(negedge Clk);
        check_reset_outputs("reset");
        Rst = 1'b0;
        idle(5);

        // Check value "123456789": FCS 26 39 F4 CB.
        p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send(p, -1, 1'b1, 1'b1, 32'hCBF4_3926);
        idle(30);

        // Single zero byte: FCS 8D EF 02 D2.
        p = '{8'h00};
        send(p, -1, 1'b1, 1'b1, 32'hD202_EF8D);
        idle(30);

        // Back-to-back with the minimum legal input gap.
        send(rand_bytes(15), -1, 1'b1, 1'b0, 32'h0);
        idle(IFG_LEN + 11);
        send(rand_bytes(7), -1, 1'b1, 1'b0, 32'h0);
        idle(40);
        check("fcs_to_preamble", last_gap, IFG_LEN);

        // One cycle too early: second frame dropped, third transmits.
        send(rand_bytes(10), -1, 1'b1, 1'b0, 32'h0);
        idle(IFG_LEN + 10);
        send(rand_bytes(5), -1, 1'b0, 1'b0, 32'h0);
        idle(40);
        send(rand_bytes(12), -1, 1'b1, 1'b0, 32'h0);
        idle(30);

        // Mid-frame one-cycle gap after byte 3 of 6.
        send(rand_bytes(6), 2, 1'b1, 1'b0, 32'h0);
        idle(30);

        // Reset pulse during DATA of a 40-byte frame.
        skip_frames = 1;
        p = rand_bytes(40);
        for (int i = 0; i < 13; i++) begin
            @(negedge Clk);
            bus.Input_valid = 1'b1;
            bus.Input_data  = p[i];
            bus.Input_last  = 1'b0;
        end
        @(negedge Clk);
        Rst             = 1'b1;
        bus.Input_valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        check_reset_outputs("midreset");
        idle(5);
        send(rand_bytes(20), -1, 1'b1, 1'b0, 32'h0);
        idle(30);

        // Randomized legal traffic.
        for (int f = 0; f < 200; f++) begin
            send(rand_bytes($urandom_range(1, 64)), -1, 1'b1, 1'b0, 32'h0);
            idle($urandom_range(IFG_LEN + 11, IFG_LEN + 18));
        end
        idle(60);

        check("pending_frames", exp_start_q.size(), 0);
        check("pending_overruns", exp_ovr_q.size(), 0);
        check("skip_consumed", skip_frames, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
